// File: rtl/bp_table.sv
// Direct-mapped BTB with 2-bit saturating direction counters and a one-entry-per-cycle clear sequencer.
// Lookup is combinational (zero latency); training writes at the clock edge; no backpressure, updates during clear are dropped.
module bp_table #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_addr_i,
  output logic        bp_hit_o,
  output logic        bp_taken_o,
  output logic [31:0] bp_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_addr_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        flush_i,
  output logic        init_busy_o
);

  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic [IDX_W-1:0] clr_idx, clr_idx_nxt;

  logic             valid_q  [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [1:0]       ctr_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];

  logic             tbl_we;
  logic [IDX_W-1:0] w_idx;
  logic             w_valid;
  logic [TAG_W-1:0] w_tag;
  logic [1:0]       w_ctr;
  logic [31:0]      w_target;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       upd_ctr_cur;
  logic [1:0]       upd_ctr_new;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[1:0], upd_addr_i[1:0]};

  // Lookup reads the stored contents directly, so a same-cycle update is not bypassed.
  assign lk_idx = if_addr_i[IDX_W+1:2];
  assign lk_tag = if_addr_i[31:IDX_W+2];
  assign lk_hit = (state == RUN) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign bp_hit_o    = lk_hit;
  assign bp_taken_o  = lk_hit && ctr_q[lk_idx][1];
  assign bp_target_o = lk_hit ? target_q[lk_idx] : 32'h0;
  assign init_busy_o = (state == INIT);

  assign upd_idx     = upd_addr_i[IDX_W+1:2];
  assign upd_tag     = upd_addr_i[31:IDX_W+2];
  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr_cur = ctr_q[upd_idx];

  always_comb begin
    upd_ctr_new = upd_ctr_cur;
    if (upd_taken_i) begin
      if (upd_ctr_cur != 2'b11) upd_ctr_new = upd_ctr_cur + 2'b01;
    end else begin
      if (upd_ctr_cur != 2'b00) upd_ctr_new = upd_ctr_cur - 2'b01;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    tbl_we      = 1'b0;
    w_idx       = clr_idx;
    w_valid     = 1'b0;
    w_tag       = '0;
    w_ctr       = 2'b01;
    w_target    = 32'h0;

    if (flush_i) begin
      state_nxt   = INIT;
      clr_idx_nxt = '0;
    end else begin
      case (state)
        INIT: begin
          tbl_we      = 1'b1;
          clr_idx_nxt = clr_idx + 1'b1;
          if (clr_idx == IDX_W'(DEPTH - 1)) state_nxt = RUN;
        end
        RUN: begin
          if (upd_valid_i) begin
            w_idx = upd_idx;
            w_tag = upd_tag;
            if (upd_hit) begin
              tbl_we   = 1'b1;
              w_valid  = 1'b1;
              w_ctr    = upd_ctr_new;
              w_target = upd_taken_i ? upd_target_i : target_q[upd_idx];
            end else if (upd_taken_i) begin
              // Allocation evicts whatever occupies the slot.
              tbl_we   = 1'b1;
              w_valid  = 1'b1;
              w_ctr    = 2'b10;
              w_target = upd_target_i;
            end
          end
        end
        default: begin
          state_nxt   = INIT;
          clr_idx_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && tbl_we) begin
      valid_q[w_idx]  <= w_valid;
      tag_q[w_idx]    <= w_tag;
      ctr_q[w_idx]    <= w_ctr;
      target_q[w_idx] <= w_target;
    end
  end

endmodule

// File: tb/tb_bp_table.sv
// Directed bench for bp_table: init timing, allocate/alias, counter saturation, flush and reset restart.
module tb_bp_table;

  logic        clk;
  logic        rst;
  logic [31:0] if_addr;
  logic        bp_hit;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic        upd_valid;
  logic [31:0] upd_addr;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush;
  logic        init_busy;

  int checks   = 0;
  int failures = 0;
  int n;

  bp_table #(.DEPTH(16), .IDX_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_addr_i    (if_addr),
    .bp_hit_o     (bp_hit),
    .bp_taken_o   (bp_taken),
    .bp_target_o  (bp_target),
    .upd_valid_i  (upd_valid),
    .upd_addr_i   (upd_addr),
    .upd_taken_i  (upd_taken),
    .upd_target_i (upd_target),
    .flush_i      (flush),
    .init_busy_o  (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] a, input logic h,
                      input logic t, input logic [31:0] tgt);
    if_addr = a;
    #1;
    chk({tag, ".hit"}, {31'b0, bp_hit}, {31'b0, h});
    chk({tag, ".taken"}, {31'b0, bp_taken}, {31'b0, t});
    chk({tag, ".target"}, bp_target, tgt);
  endtask

  task automatic upd(input logic [31:0] a, input logic t, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_addr   = a;
    upd_taken  = t;
    upd_target = tgt;
    tick();
    upd_valid  = 1'b0;
  endtask

  // Counts cycles with init_busy high, bounded so a stuck clear still ends the run.
  task automatic count_init(input string tag, input logic drive_upd);
    n = 0;
    while (init_busy && n < 100) begin
      if (drive_upd) begin
        upd_valid  = 1'b1;
        upd_addr   = 32'h104;
        upd_taken  = 1'b1;
        upd_target = 32'h777;
      end
      tick();
      n++;
    end
    upd_valid = 1'b0;
    chk(tag, n, 16);
  endtask

  initial begin
    rst = 1'b1; if_addr = 32'h0; upd_valid = 1'b0; upd_addr = 32'h0;
    upd_taken = 1'b0; upd_target = 32'h0; flush = 1'b0;
    tick();
    tick();
    chk("reset.busy", {31'b0, init_busy}, 32'd1);
    look("reset", 32'h100, 1'b0, 1'b0, 32'h0);

    rst = 1'b0;
    #1;
    look("init_lookup", 32'h100, 1'b0, 1'b0, 32'h0);
    count_init("init_len", 1'b0);
    look("run_empty", 32'h100, 1'b0, 1'b0, 32'h0);

    // Allocate and alias on index 0
    upd(32'h100, 1'b1, 32'h200);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
    look("alias_miss", 32'h140, 1'b0, 1'b0, 32'h0);
    upd(32'h140, 1'b1, 32'h300);
    look("evicted", 32'h100, 1'b0, 1'b0, 32'h0);
    look("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);

    // Saturation: realloc 0x100 at ctr=10
    upd(32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    look("nt1", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 1'b0, 32'h0);
    look("nt2", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 1'b0, 32'hABC);
    upd(32'h100, 1'b1, 32'h240);
    look("nt_sat_then_t", 32'h100, 1'b1, 1'b0, 32'h240);
    upd(32'h100, 1'b1, 32'h240);
    look("t2", 32'h100, 1'b1, 1'b1, 32'h240);
    upd(32'h100, 1'b1, 32'h240);
    upd(32'h100, 1'b1, 32'h240);
    upd(32'h100, 1'b1, 32'h240);
    upd(32'h100, 1'b0, 32'h999);
    look("t_sat_then_nt", 32'h100, 1'b1, 1'b1, 32'h240);
    upd(32'h100, 1'b0, 32'h999);
    look("t_sat_nt2", 32'h100, 1'b1, 1'b0, 32'h240);

    // Not-taken miss does not allocate
    upd(32'h104, 1'b0, 32'h555);
    look("nt_miss", 32'h104, 1'b0, 1'b0, 32'h0);

    // Same-cycle lookup/update on 0x100 after evicting it
    upd(32'h140, 1'b1, 32'h300);
    if_addr    = 32'h100;
    upd_valid  = 1'b1;
    upd_addr   = 32'h100;
    upd_taken  = 1'b1;
    upd_target = 32'h200;
    #1;
    chk("same_cycle.hit", {31'b0, bp_hit}, 32'd0);
    tick();
    upd_valid = 1'b0;
    look("next_cycle", 32'h100, 1'b1, 1'b1, 32'h200);

    // Flush wins over a concurrent update; updates during INIT are ignored
    upd(32'h108, 1'b1, 32'h400);
    flush = 1'b1;
    upd(32'h180, 1'b1, 32'h500);
    flush = 1'b0;
    count_init("flush_len", 1'b1);
    look("flush_180", 32'h180, 1'b0, 1'b0, 32'h0);
    look("flush_100", 32'h100, 1'b0, 1'b0, 32'h0);
    look("flush_108", 32'h108, 1'b0, 1'b0, 32'h0);
    look("init_upd", 32'h104, 1'b0, 1'b0, 32'h0);

    // Reset at INIT cycle 5 restarts the full clear
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    count_init("rst_restart_len", 1'b0);
    upd(32'h10C, 1'b1, 32'h600);
    look("post_restart", 32'h10C, 1'b1, 1'b1, 32'h600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
